mac_acc_array: RTL and testbench
================================

# mac_acc_array

Parametrised multiply-accumulate array that computes signed fixed-point dot products. Each accepted beat applies LANES parallel multiplies (ifm × w) and reduces them with an adder tree. A wide accumulator sums beats until a beat tagged last, then emits one rounded, saturated result. It sits between the feature-map/weight fetch logic and the output-feature-map writer, with valid/ready handshakes on both sides. Multipliers are inferred, not vendor IP.

## Interface
- LANES, 4, number of parallel multiply lanes (power of two, ≥1)
- DW, 16, width of each ifm/w operand and of the result (signed two's complement)
- FRAC, 8, fractional bits of operands and result (Q(DW-FRAC).FRAC); 1 ≤ FRAC < DW
- ACC_W, 40, accumulator width; must be ≥ 2*DW + clog2(LANES)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  beat present on ifm/w/in_last
- in_ready  out  1  block accepts beat this cycle
- in_last  in  1  beat is the final term of the current dot product
- ifm  in  LANES*DW  lane i at bits [i*DW +: DW]
- w  in  LANES*DW  lane i at bits [i*DW +: DW]
- out_valid  out  1  result holding on out_data
- out_ready  in  1  consumer accepts result
- out_data  out  DW  rounded, saturated dot product
- out_sat  out  1  out_data was clipped (qualified by out_valid)

## Operation
- Beat accepted when in_valid & in_ready.
- Stage P (products): p[i] = signed(ifm_i) * signed(w_i), 2*DW bits, registered.
- Stage S (sum): s = Σ p[i], width 2*DW+clog2(LANES), sign-extended, registered with the beat's last flag.
- Stage A (accumulate): acc_next = (first ? 0 : acc) + sext(s, ACC_W), wrapping modulo 2^ACC_W.
  - first is set after reset and after every last beat.
  - No overflow detection on acc; ACC_W sizing is the user's responsibility.
- On a last beat in stage A, the result register loads:
  - r = (acc_next + 2^(FRAC-1)) >>> FRAC (arithmetic shift, round half up).
  - Saturate r to [-2^(DW-1), 2^(DW-1)-1]; out_sat = 1 if clipped.
  - out_valid is set, and first is set again.
- A single-beat dot product (in_last on the first beat) is legal.
- Stall: stall = out_valid & ~out_ready & (a last beat would reach the result register next cycle); conservatively, stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stalled, all pipeline stages and acc hold.
- out_valid clears on out_valid & out_ready unless a new result loads the same cycle, in which case it stays 1 with new data.
- Bubbles (no accepted beat) propagate as invalid stages and never alter acc.

## Timing
- Reset values: in_ready=0 during the reset cycle, then 1. out_valid=0, out_data=0, out_sat=0. All stage valids=0, acc=0, first=1.
- Reset mid-dot-product discards the partial sum and any in-flight beats. A pending result is dropped.
- Latency: a last beat accepted at edge t gives out_valid=1 after edge t+3, with no stall.
- Throughput is one beat per cycle while out_ready is high. Back-to-back dot products need no gap cycles.
- With out_ready low and out_valid high, in_ready is low combinationally in the same cycle. Data is never lost or duplicated.
- Simultaneous out handshake and new result: the new result replaces the old one on the same edge.

## Test plan
- Basic, Q8.8, LANES=4: one beat with all ifm=0x0100 (1.0), w=0x0200 (2.0), in_last=1 -> after 3 cycles out_data=0x0800 (8.0), out_sat=0.
- Multi-beat: 3 beats each with ifm=0x0080 (0.5), w=0xFF00 (-1.0), last on beat 3 -> single result out_data=0xFA00 (-6.0). No out_valid on beats 1–2.
- Rounding: ifm lane0=0x0001, w lane0=0x0080, other lanes 0 -> raw 0x80 rounds up, out_data=0x0001. With w lane0=0x007F -> out_data=0x0000.
- Saturation: all lanes ifm=0x7FFF, w=0x7FFF, last -> out_data=0x7FFF, out_sat=1. All lanes ifm=0x8000, w=0x7FFF -> out_data=0x8000, out_sat=1.
- Backpressure: stream 4 single-beat products while out_ready is held low for 5 cycles. in_ready drops once out_valid=1, and all 4 results emerge in order once out_ready rises.
- Reset mid-operation: accept 2 non-last beats, assert rst one cycle, then send one last beat of 1.0×1.0 on all lanes -> out_data=0x0400 with no contribution from the pre-reset beats.

Source files
------------

// File: rtl/mac_acc_array.sv
// mac_acc_array: signed fixed-point dot-product engine.
// Pipeline: I (input regs) -> P (lane products) -> S (adder tree) -> A (accumulate,
// round, saturate into the result register). Valid/ready on both sides; the whole
// pipeline freezes while a finished result is waiting for the consumer.
module mac_acc_array #(
  parameter int LANES = 4,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [LANES*DW-1:0]   ifm,
  input  logic [LANES*DW-1:0]   w,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic                  out_sat
);

  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW + $clog2(LANES);

  // Saturation bounds and rounding constant, held one bit wider than the
  // accumulator so adding the half-LSB can never wrap.
  localparam logic signed [ACC_W:0] R_MAX = {{(ACC_W + 2 - DW){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [ACC_W:0] R_MIN = {{(ACC_W + 2 - DW){1'b1}}, {(DW - 1){1'b0}}};
  localparam logic signed [ACC_W:0] HALF  = (ACC_W + 1)'(1) << (FRAC - 1);

  // Stage I: registered input beat
  logic                  i_vld_q, i_vld_d, i_last_q, i_last_d;
  logic [LANES*DW-1:0]   i_ifm_q, i_ifm_d, i_w_q, i_w_d;
  // Stage P: per-lane products
  logic                  p_vld_q, p_vld_d, p_last_q, p_last_d;
  logic signed [PW-1:0]  p_q [LANES];
  logic signed [PW-1:0]  p_d [LANES];
  // Stage S: reduced sum
  logic                  s_vld_q, s_vld_d, s_last_q, s_last_d;
  logic signed [SW-1:0]  s_q, s_d;
  // Stage A: accumulator and result register
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    first_q, first_d;
  logic                    out_valid_q, out_valid_d;
  logic [DW-1:0]           out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  logic                    stall, accept;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W:0]   rnd, r;

  // Accumulate, round half up and shift back to the operand scale.
  always_comb begin
    acc_sum = (first_q ? '0 : acc_q) + ACC_W'(s_q);
    rnd     = (ACC_W + 1)'(acc_sum) + HALF;
    r       = rnd >>> FRAC;
  end

  // Handshake, stage advance and result load; everything holds while stalled.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    stall       = out_valid_q & ~out_ready;
    in_ready    = ~rst & ~stall;
    accept      = in_valid & in_ready;
    i_vld_d     = i_vld_q;
    i_last_d    = i_last_q;
    i_ifm_d     = i_ifm_q;
    i_w_d       = i_w_q;
    p_vld_d     = p_vld_q;
    p_last_d    = p_last_q;
    p_d         = p_q;
    s_vld_d     = s_vld_q;
    s_last_d    = s_last_q;
    s_d         = s_q;
    acc_d       = acc_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (!stall) begin
      i_vld_d  = accept;
      i_last_d = in_last;
      i_ifm_d  = ifm;
      i_w_d    = w;

      p_vld_d  = i_vld_q;
      p_last_d = i_last_q;
      for (int i = 0; i < LANES; i++) begin
        p_d[i] = $signed(i_ifm_q[i*DW +: DW]) * $signed(i_w_q[i*DW +: DW]);
      end

      s_vld_d  = p_vld_q;
      s_last_d = p_last_q;
      s_d      = '0;
      for (int i = 0; i < LANES; i++) begin
        s_d = s_d + SW'(p_q[i]);
      end

      // A consumed result drops out_valid unless a new one replaces it below.
      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      if (s_vld_q) begin
        acc_d   = acc_sum;
        first_d = s_last_q;
        if (s_last_q) begin
          out_valid_d = 1'b1;
          if (r > R_MAX) begin
            out_data_d = R_MAX[DW-1:0];
            out_sat_d  = 1'b1;
          end else if (r < R_MIN) begin
            out_data_d = R_MIN[DW-1:0];
            out_sat_d  = 1'b1;
          end else begin
            out_data_d = r[DW-1:0];
            out_sat_d  = 1'b0;
          end
        end
      end
    end
  end

  // State registers with synchronous reset; a reset drops any partial sum,
  // in-flight beats and a pending result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      i_vld_q     <= 1'b0;
      i_last_q    <= 1'b0;
      i_ifm_q     <= '0;
      i_w_q       <= '0;
      p_vld_q     <= 1'b0;
      p_last_q    <= 1'b0;
      // NOTE: the product array is small flop storage, not RAM, so resetting it is cheap.
      for (int i = 0; i < LANES; i++) p_q[i] <= '0;
      s_vld_q     <= 1'b0;
      s_last_q    <= 1'b0;
      s_q         <= '0;
      acc_q       <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      i_vld_q     <= i_vld_d;
      i_last_q    <= i_last_d;
      i_ifm_q     <= i_ifm_d;
      i_w_q       <= i_w_d;
      p_vld_q     <= p_vld_d;
      p_last_q    <= p_last_d;
      p_q         <= p_d;
      s_vld_q     <= s_vld_d;
      s_last_q    <= s_last_d;
      s_q         <= s_d;
      acc_q       <= acc_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mac_acc_array.sv
// Directed bench for mac_acc_array: stimulus pushes hand-computed results into a
// scoreboard queue; an independent monitor pops and compares on every output handshake.
module tb_mac_acc_array;

  localparam int LANES = 4;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 40;

  logic                clk = 1'b0;
  logic                rst, in_valid, in_ready, in_last;
  logic [LANES*DW-1:0] ifm, w;
  logic                out_valid, out_ready, out_sat;
  logic [DW-1:0]       out_data;

  int tests = 0;
  int fails = 0;
  logic [DW:0] exp_q [$];   // {sat, data}

  mac_acc_array #(.LANES(LANES), .DW(DW), .FRAC(FRAC), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .ifm(ifm), .w(w),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LANES*DW-1:0] bcast(input logic [DW-1:0] v);
    return {LANES{v}};
  endfunction

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b,
                      input logic last);
    logic ok;
    ok       = 1'b0;
    ifm      = a;
    w        = b;
    in_last  = last;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every delivered result against the scoreboard head.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e[DW-1:0]));
        check("out_sat", 32'(out_sat), 32'(e[DW]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    ifm = '0; w = '0; out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("in_ready_in_reset", 32'(in_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    check("out_valid_reset", 32'(out_valid), 32'd0);
    check("out_data_reset", 32'(out_data), 32'd0);
    check("out_sat_reset", 32'(out_sat), 32'd0);
    @(posedge clk); #1;

    // Basic 1.0 x 2.0 on 4 lanes = 8.0, with latency check
    exp_q.push_back({1'b0, 16'h0800});
    send(bcast(16'h0100), bcast(16'h0200), 1'b1);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    drain();

    // Multi-beat: 3 x (4 x 0.5 x -1.0) = -6.0
    send(bcast(16'h0080), bcast(16'hFF00), 1'b0);
    send(bcast(16'h0080), bcast(16'hFF00), 1'b0);
    exp_q.push_back({1'b0, 16'hFA00});
    send(bcast(16'h0080), bcast(16'hFF00), 1'b1);
    drain();

    // Rounding boundaries, lane 0 only (raw +128, +127, -128, -129)
    exp_q.push_back({1'b0, 16'h0001});
    send(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0080, 1'b1);
    exp_q.push_back({1'b0, 16'h0000});
    send(64'h0000_0000_0000_0001, 64'h0000_0000_0000_007F, 1'b1);
    exp_q.push_back({1'b0, 16'h0000});
    send(64'h0000_0000_0000_0001, 64'h0000_0000_0000_FF80, 1'b1);
    exp_q.push_back({1'b0, 16'hFFFF});
    send(64'h0000_0000_0000_0001, 64'h0000_0000_0000_FF7F, 1'b1);
    drain();

    // Saturation both directions
    exp_q.push_back({1'b1, 16'h7FFF});
    send(bcast(16'h7FFF), bcast(16'h7FFF), 1'b1);
    exp_q.push_back({1'b1, 16'h8000});
    send(bcast(16'h8000), bcast(16'h7FFF), 1'b1);
    drain();

    // Backpressure: 4 single-beat products with out_ready low for 5 cycles
    out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++) begin
          exp_q.push_back({1'b0, 16'(k * 16'h0400)});
          send(bcast(16'h0100), bcast(16'(k << 8)), 1'b1);
        end
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-operation discards the partial sum
    send(bcast(16'h0100), bcast(16'h0100), 1'b0);
    send(bcast(16'h0100), bcast(16'h0100), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("in_ready_mid_reset", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back({1'b0, 16'h0400});
    send(bcast(16'h0100), bcast(16'h0100), 1'b1);
    drain();
    check("idle_out_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
